cci_mpf_shim_vtp_svc_client_rob: RTL

Client end of the VTP translation service interface, instantiated once per VTP pipeline shim.
- Accepts in-order 4KB-page translation requests from the shim pipeline and allocates a dynamically unique tag per request.
- Issues each request to the shared VTP service, which may answer out of order.
- Collects responses by tag in a reorder buffer and retires translations to the pipeline strictly in request order.

---
 rtl/cci_mpf_shim_vtp_svc_client_rob.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/cci_mpf_shim_vtp_svc_client_rob.sv
// VTP service client: tags in-order translation requests, issues them to the shared service and
// retires out-of-order responses in request order. Optional bypass: CCI_MPF_VTP_SVC_CLIENT_LAST_XLATE_EN.

module cci_mpf_shim_vtp_svc_client_rob #(
   parameter int unsigned N_TAGS = 16,
   parameter int unsigned VA_W = 36,
   parameter int unsigned PA_W = 40,
   localparam int unsigned TAG_W = $clog2(N_TAGS)
) (
   input  logic             clk,
   input  logic             reset,

   input  logic             reqEn,
   input  logic [VA_W-1:0]  reqPageVA,
   input  logic             reqIsSpeculative,
   output logic             reqRdy,

   output logic             svcLookupEn,
   output logic [VA_W-1:0]  svcLookupReqPageVA,
   output logic             svcLookupReqIsSpeculative,
   output logic [TAG_W-1:0] svcLookupReqTag,
   input  logic             svcLookupRdy,
   input  logic             svcLookupRspValid,
   input  logic [PA_W-1:0]  svcLookupRspPagePA,
   input  logic             svcLookupRspError,
   input  logic [TAG_W-1:0] svcLookupRspTag,
   input  logic             svcLookupRspIsBigPage,

   output logic             rspValid,
   output logic [PA_W-1:0]  rspPagePA,
   output logic             rspIsBigPage,
   output logic             rspError,
   input  logic             rspDeq
);

   localparam logic [TAG_W:0] FULL_CNT = (TAG_W+1)'(N_TAGS);

   typedef enum logic [1:0] {SlotFree, SlotPending, SlotDone} t_slot_state;

   t_slot_state      slotState [N_TAGS];
   logic [PA_W-1:0]  slotPA [N_TAGS];
   logic             slotIsBigPage [N_TAGS];
   logic             slotError [N_TAGS];
   logic [TAG_W-1:0] allocPtr, retirePtr;
   logic [TAG_W:0]   cnt;
   logic             notFull, accept, deq, rspWrite, hit;

   assign notFull  = (cnt != FULL_CNT);
   assign accept   = reqEn && reqRdy;
   assign deq      = rspDeq && rspValid;
   // Responses to slots that are not waiting are dropped.
   assign rspWrite = svcLookupRspValid && (slotState[svcLookupRspTag] == SlotPending);

`ifdef CCI_MPF_VTP_SVC_CLIENT_LAST_XLATE_EN
   logic [VA_W-1:0] slotVA [N_TAGS];
   logic            lastValid;
   logic [VA_W-1:0] lastVA;
   logic [PA_W-1:0] lastPA;
   logic            lastIsBigPage;
   logic [PA_W-1:0] hitPA;

   // A 2MB translation covers every 4KB page sharing VA[VA_W-1:9].
   assign hit = lastValid && (lastIsBigPage ? (reqPageVA[VA_W-1:9] == lastVA[VA_W-1:9])
                                            : (reqPageVA == lastVA));
   assign hitPA  = lastIsBigPage ? {lastPA[PA_W-1:9], reqPageVA[8:0]} : lastPA;
   assign reqRdy = !reset && notFull && (svcLookupRdy || hit);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lastValid     <= 1'b0;
         lastVA        <= '0;
         lastPA        <= '0;
         lastIsBigPage <= 1'b0;
      end else if (deq && !slotError[retirePtr]) begin
         lastValid     <= 1'b1;
         lastVA        <= slotVA[retirePtr];
         lastPA        <= slotPA[retirePtr];
         lastIsBigPage <= slotIsBigPage[retirePtr];
      end
   end

   always_ff @(posedge clk) begin
      if (accept) slotVA[allocPtr] <= reqPageVA;
   end
`else
   assign hit    = 1'b0;
   assign reqRdy = !reset && notFull && svcLookupRdy;
`endif

   // Accept, response and deq always target three distinct slots.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < N_TAGS; i++) slotState[i] <= SlotFree;
         allocPtr  <= '0;
         retirePtr <= '0;
         cnt       <= '0;
      end else begin
         if (accept) begin
            slotState[allocPtr] <= hit ? SlotDone : SlotPending;
            allocPtr <= allocPtr + TAG_W'(1);
         end
         if (rspWrite) slotState[svcLookupRspTag] <= SlotDone;
         if (deq) begin
            slotState[retirePtr] <= SlotFree;
            retirePtr <= retirePtr + TAG_W'(1);
         end
         cnt <= cnt + (TAG_W+1)'(accept) - (TAG_W+1)'(deq);
      end
   end

   always_ff @(posedge clk) begin
      if (rspWrite) begin
         slotPA[svcLookupRspTag]        <= svcLookupRspPagePA;
         slotIsBigPage[svcLookupRspTag] <= svcLookupRspIsBigPage;
         slotError[svcLookupRspTag]     <= svcLookupRspError;
      end
`ifdef CCI_MPF_VTP_SVC_CLIENT_LAST_XLATE_EN
      if (accept && hit) begin
         slotPA[allocPtr]        <= hitPA;
         slotIsBigPage[allocPtr] <= lastIsBigPage;
         slotError[allocPtr]     <= 1'b0;
      end
`endif
   end

   assign svcLookupEn               = accept && !hit;
   assign svcLookupReqPageVA        = reqPageVA;
   assign svcLookupReqIsSpeculative = reqIsSpeculative;
   assign svcLookupReqTag           = allocPtr;

   assign rspValid     = (slotState[retirePtr] == SlotDone);
   assign rspPagePA    = slotPA[retirePtr];
   assign rspIsBigPage = slotIsBigPage[retirePtr];
   assign rspError     = slotError[retirePtr];

`ifndef SYNTHESIS
   assert property (@(posedge clk) disable iff (reset) rspDeq |-> rspValid);
   assert property (@(posedge clk) disable iff (reset)
                    svcLookupRspValid |-> (slotState[svcLookupRspTag] == SlotPending));
   assert property (@(posedge clk) disable iff (reset) cnt <= FULL_CNT);
   assert property (@(posedge clk) disable iff (reset) !(deq && (cnt == '0)));
`endif

endmodule
